scene_renderer: RTL and testbench

SCENE_RENDERER -- requirements
Module: scene_renderer

---
 rtl/scene_renderer.sv | 175 +++++++++++++++++
 tb/tb_scene_renderer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_renderer.sv
// scene_renderer: VGA-style raster generator and sprite compositor for a
// side-scrolling dino game.
//
// Ports:
//   clk         pixel clock (25 MHz at the default 640x480 timing)
//   reset       synchronous, active-low reset
//   state       game state: 0 = active, 1 = game over (background flashes)
//   dinoX/dinoY dino box top-left corner
//   obsX/obsY   obstacle left edge and top edge (obstacle extends down to
//               the floor row V_ACTIVE-SPRITE_W)
//   hsync       active-low horizontal sync, aligned with rgb
//   vsync       active-low vertical sync, aligned with rgb
//   rgb         {R[3:0], G[3:0], B[3:0]} pixel colour, 2 clk behind the raster
//   frame_tick  one-cycle pulse at the start of vertical blank
//
// Porch and sync widths are parameters so that a scaled-down raster can be
// used; their defaults give the standard 800x525 total timing.
module scene_renderer #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPRITE_W    = 20,
  parameter int FLASH_SHIFT = 4,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        state,
  input  logic [11:0] dinoX,
  input  logic [11:0] dinoY,
  input  logic [11:0] obsX,
  input  logic [11:0] obsY,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);

  // 13-bit geometry constants so that coordinate + SPRITE_W never wraps
  localparam logic [12:0] SPR        = 13'(SPRITE_W);
  localparam logic [12:0] OBS_FLOOR  = 13'(V_ACTIVE - SPRITE_W);
  localparam logic [12:0] GROUND_TOP = 13'(V_ACTIVE - 2);

  logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        tick_q, tick_d;
  logic [7:0]  frameCnt_q;
  logic        state_q;
  logic [11:0] dinoX_q, dinoY_q, obsX_q, obsY_q;

  // Raster counters: vcnt steps when hcnt wraps
  always_comb begin
    hcnt_d = hcnt_q + 12'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 12'd1;
    end
    tick_d = (hcnt_d == '0) && (vcnt_d == V_VIS);
  end

  // Shadow registers are captured at the end of the tick cycle, which falls
  // in vertical blank, so a whole visible frame always sees one snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      tick_q     <= 1'b0;
      frameCnt_q <= '0;
      state_q    <= 1'b0;
      dinoX_q    <= 12'd50;
      dinoY_q    <= 12'd460;
      obsX_q     <= 12'd650;
      obsY_q     <= 12'd379;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      tick_q <= tick_d;
      if (tick_q) begin
        frameCnt_q <= frameCnt_q + 8'd1;
        state_q    <= state;
        dinoX_q    <= dinoX;
        dinoY_q    <= dinoY;
        obsX_q     <= obsX;
        obsY_q     <= obsY;
      end
    end
  end

  assign frame_tick = tick_q;

  // Stage 1: region tests on the current raster position
  logic [12:0] px, py;
  logic        visible_d, dinoHit_d, obsHit_d, ground_d, flash_d;
  logic        hsync1_d, vsync1_d;

  always_comb begin
    px        = {1'b0, hcnt_q};
    py        = {1'b0, vcnt_q};
    visible_d = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    dinoHit_d = (px >= {1'b0, dinoX_q}) && (px < {1'b0, dinoX_q} + SPR) &&
                (py >= {1'b0, dinoY_q}) && (py < {1'b0, dinoY_q} + SPR);
    // obsX[11] set means the obstacle has scrolled past x=0 and wrapped
    obsHit_d  = !obsX_q[11] &&
                (px >= {1'b0, obsX_q}) && (px < {1'b0, obsX_q} + SPR) &&
                (py >= {1'b0, obsY_q}) && (py < OBS_FLOOR);
    ground_d  = (py >= GROUND_TOP);
    flash_d   = state_q && frameCnt_q[FLASH_SHIFT];
    hsync1_d  = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
    vsync1_d  = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
  end

  logic visible_q, dinoHit_q, obsHit_q, ground_q, flash_q;
  logic hsync1_q, vsync1_q, hsync2_q, vsync2_q;
  logic [11:0] rgb_q, rgb_d;

  // Stage 2: priority colour mux, dino over obstacle over ground
  always_comb begin
    rgb_d = 12'h000;
    if (visible_q) begin
      if (dinoHit_q)     rgb_d = 12'h0A0;
      else if (obsHit_q) rgb_d = 12'hA00;
      else if (ground_q) rgb_d = 12'h555;
      else if (flash_q)  rgb_d = 12'hF88;
      else               rgb_d = 12'hFFF;
    end
  end

  // Pipeline registers; syncs travel two stages to stay aligned with rgb
  always_ff @(posedge clk) begin
    if (!reset) begin
      visible_q <= 1'b0;
      dinoHit_q <= 1'b0;
      obsHit_q  <= 1'b0;
      ground_q  <= 1'b0;
      flash_q   <= 1'b0;
      hsync1_q  <= 1'b1;
      vsync1_q  <= 1'b1;
      hsync2_q  <= 1'b1;
      vsync2_q  <= 1'b1;
      rgb_q     <= 12'h000;
    end else begin
      visible_q <= visible_d;
      dinoHit_q <= dinoHit_d;
      obsHit_q  <= obsHit_d;
      ground_q  <= ground_d;
      flash_q   <= flash_d;
      hsync1_q  <= hsync1_d;
      vsync1_q  <= vsync1_d;
      hsync2_q  <= hsync1_q;
      vsync2_q  <= vsync1_q;
      rgb_q     <= rgb_d;
    end
  end

  assign hsync = hsync2_q;
  assign vsync = vsync2_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_scene_renderer.sv
// tb_scene_renderer: directed bench for scene_renderer on a scaled-down
// raster (32x24 visible, 48x30 total, 4-pixel sprites, flash on counter
// bit 1). A bench-side raster tracker delays its coordinates by two cycles
// and files every output pixel into a frame buffer, so whole frames can be
// inspected after each frame_tick.
module tb_scene_renderer;

  localparam int HA = 32, VA = 24, SW = 4, FS = 1;
  localparam int HF = 4, HS = 8, HB = 4, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        state = 1'b0;
  logic [11:0] dinoX = '0, dinoY = '0, obsX = '0, obsY = '0;
  logic        hsync, vsync, frame_tick;
  logic [11:0] rgb;

  int checks = 0;
  int failures = 0;

  int th = 0, tv = 0, th1 = 0, tv1 = 0, th2 = 0, tv2 = 0, fcnt = 0;
  logic [11:0] fbRgb [VT][HT];
  logic        fbHs  [VT][HT];
  logic        fbVs  [VT][HT];

  always #5 clk = ~clk;

  scene_renderer #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SPRITE_W(SW), .FLASH_SHIFT(FS),
    .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .state(state),
    .dinoX(dinoX), .dinoY(dinoY), .obsX(obsX), .obsY(obsY),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
  );

  // Expected raster position, with a two-cycle delayed copy for the
  // pipeline, and the expected frame-counter value.
  always @(posedge clk) begin
    th1 <= th; tv1 <= tv;
    th2 <= th1; tv2 <= tv1;
    if (!reset) begin
      th <= 0; tv <= 0; fcnt <= 0;
    end else begin
      if (th == 0 && tv == VA) fcnt <= fcnt + 1;
      if (th == HT - 1) begin
        th <= 0;
        tv <= (tv == VT - 1) ? 0 : tv + 1;
      end else begin
        th <= th + 1;
      end
    end
  end

  // File each output pixel under the raster position that produced it
  always @(negedge clk) begin
    fbRgb[tv2][th2] <= rgb;
    fbHs[tv2][th2]  <= hsync;
    fbVs[tv2][th2]  <= vsync;
  end

  initial begin
    #(90000 * 10);
    $display("[TB] FAIL watchdog: observed no end of test, expected finish within 90000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return hsync;
      1:       return vsync;
      default: return frame_tick;
    endcase
  endfunction

  // Step cycles until the selected output reaches level; n counts the steps
  task automatic waitFor(input int which, input logic level, input int budget, output int n);
    n = 0;
    while (sig(which) !== level && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic waitTick();
    int g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (frame_tick !== 1'b1 && g < 2 * FRAME);
    checkOutput("tick_arrives", frame_tick, 1);
  endtask

  task automatic waitCounter(input int x, input int y);
    int g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (!(th == x && tv == y) && g < 2 * FRAME);
  endtask

  task automatic applyStimulus(input logic st, input int dx, input int dy, input int ox, input int oy);
    state = st;
    dinoX = 12'(dx);
    dinoY = 12'(dy);
    obsX  = 12'(ox);
    obsY  = 12'(oy);
  endtask

  task automatic countColour(input logic [11:0] c, output int n);
    n = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (fbRgb[y][x] === c) n++;
  endtask

  initial begin
    int n, m, lo, hi, flashes;

    // Reset with inputs already pointing at on-screen positions
    applyStimulus(1'b0, 5, 20, 40, 5);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rgb", rgb, 12'h000);
    checkOutput("reset_hsync", hsync, 1);
    checkOutput("reset_vsync", vsync, 1);
    checkOutput("reset_tick", frame_tick, 0);
    reset = 1'b1;

    waitFor(2, 1'b1, 2 * FRAME, n);
    checkOutput("first_tick_latency", n, VA * HT);
    // Frame 0 still draws the reset shadow values (sprites off-screen)
    checkOutput("frame0_shadow_default", fbRgb[20][5], 12'hFFF);
    checkOutput("frame0_ground", fbRgb[22][0], 12'h555);

    waitFor(2, 1'b0, 2 * FRAME, n);
    checkOutput("tick_width", n, 1);
    waitFor(2, 1'b1, 2 * FRAME, m);
    checkOutput("tick_period", n + m, FRAME);

    // Frame 1 used the latched inputs: dino standing on the floor
    checkOutput("dino_top_left", fbRgb[20][5], 12'h0A0);
    checkOutput("dino_bottom_right", fbRgb[23][8], 12'h0A0);
    checkOutput("ground_past_dino", fbRgb[23][9], 12'h555);
    checkOutput("bg_left_of_dino", fbRgb[21][4], 12'hFFF);
    checkOutput("hblank_black", fbRgb[10][32], 12'h000);
    checkOutput("vblank_black", fbRgb[25][3], 12'h000);
    checkOutput("hsync_before", fbHs[3][35], 1);
    checkOutput("hsync_first_low", fbHs[3][36], 0);
    checkOutput("hsync_last_low", fbHs[3][43], 0);
    checkOutput("hsync_after", fbHs[3][44], 1);
    checkOutput("vsync_before", fbVs[25][0], 1);
    checkOutput("vsync_low", fbVs[26][0], 0);

    waitFor(0, 1'b0, 2 * HT, n);
    waitFor(0, 1'b1, 2 * HT, lo);
    waitFor(0, 1'b0, 2 * HT, hi);
    checkOutput("hsync_low_width", lo, HS);
    checkOutput("hsync_period", lo + hi, HT);
    waitFor(1, 1'b0, 2 * FRAME, n);
    waitFor(1, 1'b1, 2 * FRAME, lo);
    waitFor(1, 1'b0, 2 * FRAME, hi);
    checkOutput("vsync_low_width", lo, VS * HT);
    checkOutput("vsync_period", lo + hi, FRAME);

    // Obstacle spans x 7..10, y 3..19; dino x 5..8, y 17..20 overlaps it
    applyStimulus(1'b0, 5, 17, 7, 3);
    waitTick(); waitTick();
    checkOutput("obs_top_left", fbRgb[3][7], 12'hA00);
    checkOutput("bg_left_of_obs", fbRgb[10][6], 12'hFFF);
    checkOutput("dino_over_obs", fbRgb[18][8], 12'h0A0);
    checkOutput("obs_right_of_dino", fbRgb[18][9], 12'hA00);
    checkOutput("obs_bottom_right", fbRgb[19][10], 12'hA00);
    checkOutput("bg_right_of_obs", fbRgb[19][11], 12'hFFF);
    checkOutput("obs_floor", fbRgb[20][10], 12'hFFF);
    countColour(12'hA00, n);
    checkOutput("obs_pixel_count", n, 62);
    countColour(12'h0A0, n);
    checkOutput("dino_pixel_count", n, 16);

    // Obstacle underflowed past the left edge
    applyStimulus(1'b0, 5, 17, 4090, 0);
    waitTick(); waitTick();
    countColour(12'hA00, n);
    checkOutput("underflow_no_obs", n, 0);

    // Move the dino mid-frame; the move must wait for the next frame
    applyStimulus(1'b0, 5, 20, 4090, 0);
    waitTick(); waitTick();
    waitCounter(0, 10);
    dinoY = 12'd12;
    waitTick();
    checkOutput("tear_old_position", fbRgb[20][5], 12'h0A0);
    checkOutput("tear_not_early", fbRgb[13][5], 12'hFFF);
    waitTick();
    checkOutput("tear_new_position", fbRgb[13][5], 12'h0A0);
    checkOutput("tear_old_cleared", fbRgb[20][5], 12'hFFF);

    // Game over: background flashes with frame-counter bit FS
    state = 1'b1;
    flashes = 0;
    for (int f = 0; f < 8; f++) begin
      waitTick();
      checkOutput("flash_bg", fbRgb[5][20], ((fcnt >> FS) & 1) != 0 ? 12'hF88 : 12'hFFF);
      if (fbRgb[5][20] === 12'hF88) flashes++;
    end
    checkOutput("flash_frames_of_8", flashes, 4);

    // Reset during the sync pulses
    waitCounter(40, 26);
    checkOutput("pre_reset_hsync", hsync, 0);
    checkOutput("pre_reset_vsync", vsync, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_rgb", rgb, 12'h000);
    checkOutput("midreset_hsync", hsync, 1);
    checkOutput("midreset_vsync", vsync, 1);
    checkOutput("midreset_tick", frame_tick, 0);
    reset = 1'b1;
    waitFor(2, 1'b1, 2 * FRAME, n);
    checkOutput("restart_latency", n, VA * HT);
    // Frame counter restarted: 1 then 2, so flash appears on the second
    waitTick();
    checkOutput("post_reset_bg_cnt1", fbRgb[5][20], 12'hFFF);
    waitTick();
    checkOutput("post_reset_bg_cnt2", fbRgb[5][20], 12'hF88);

    // Reset while a visible ground pixel is on the output
    waitCounter(2, 22);
    checkOutput("pre_reset_ground", rgb, 12'h555);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_rgb_visible", rgb, 12'h000);
    reset = 1'b1;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
